// File: rtl/coherence_pkg.sv
// Shared types for the coherence bus controller: FSM states, RAM handshake and beat-counter sizing.
package coherence_pkg;

  typedef enum logic [2:0] {
    IDLE,
    IFETCH,
    WB,
    SNOOP,
    C2C,
    M2C,
    INV
  } ctrl_state_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  // Beat counter width; a single-word block still needs one bit.
  function automatic int unsigned beat_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/coherence_bus_ctrl_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr_i, wrapping N-1 -> 0.
module rr_arbiter #(
  parameter  int unsigned N     = 2,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o
);

  logic             found;
  logic [IDX_W-1:0] k;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    k       = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k = IDX_W'((32'(ptr_i) + i) % N);
      if (!found && req_i[k]) begin
        found      = 1'b1;
        grant_o[k] = 1'b1;
        idx_o      = k;
      end
    end
  end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// MSI snooping bus controller: round-robin over I/D ports, cache-to-cache transfer, block bursts to one RAM port.
// Optional COHERENCE_STATS_EN adds saturating C2C/M2C/INV transaction counters.
module coherence_bus_ctrl
  import coherence_pkg::*;
#(
  parameter int unsigned CPUS        = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned BLOCK_WORDS = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS*ADDR_W-1:0] iaddr,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS*WORD_W-1:0] iload,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS*ADDR_W-1:0] daddr,
  input  logic [CPUS*WORD_W-1:0] dstore,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS*WORD_W-1:0] dload,
  input  logic [CPUS-1:0]        ccwrite,
  input  logic [CPUS-1:0]        cctrans,
  output logic [CPUS-1:0]        ccwait,
  output logic [CPUS-1:0]        ccinv,
  output logic [CPUS*ADDR_W-1:0] ccsnoopaddr,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [ADDR_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  input  logic [WORD_W-1:0]      ramload,
  input  ramstate_t              ramstate
`ifdef COHERENCE_STATS_EN
  ,
  output logic [15:0]            stat_c2c,
  output logic [15:0]            stat_m2c,
  output logic [15:0]            stat_inv
`endif
);

  localparam int unsigned IDX_W     = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int unsigned BEAT_W    = beat_width(BLOCK_WORDS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(CPUS - 1);

  ctrl_state_t       state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d, req_q, req_d, src_q, src_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [CPUS-1:0]   d_req, d_grant, i_grant, req_oh, src_cand;
  logic [IDX_W-1:0]  d_idx, i_idx;
  logic              access, last_beat;
  logic [ADDR_W-1:0] req_daddr;
  logic [WORD_W-1:0] req_dstore, src_dstore;

  assign d_req      = dREN | dWEN | ccwrite;
  assign access     = (ramstate == ACCESS);
  assign last_beat  = access && (beat_q == LAST_BEAT);
  assign req_oh     = CPUS'(1) << req_q;
  assign src_cand   = cctrans & ~req_oh;
  assign req_daddr  = daddr[req_q*ADDR_W +: ADDR_W];
  assign req_dstore = dstore[req_q*WORD_W +: WORD_W];
  assign src_dstore = dstore[src_q*WORD_W +: WORD_W];

  // Data-side requests share one pointer with instruction fetches; D class always wins.
  rr_arbiter #(.N(CPUS)) u_d_arb (.req_i(d_req), .ptr_i(rr_ptr_q), .grant_o(d_grant), .idx_o(d_idx));
  rr_arbiter #(.N(CPUS)) u_i_arb (.req_i(iREN),  .ptr_i(rr_ptr_q), .grant_o(i_grant), .idx_o(i_idx));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      req_q    <= '0;
      src_q    <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      req_q    <= req_d;
      src_q    <= src_d;
      beat_q   <= beat_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    req_d    = req_q;
    src_d    = src_q;
    beat_d   = beat_q;
    case (state_q)
      IDLE: begin
        beat_d = '0;
        if (|d_grant) begin
          req_d    = d_idx;
          rr_ptr_d = (d_idx == LAST_IDX) ? '0 : d_idx + IDX_W'(1);
          if (|(d_grant & dREN))      state_d = SNOOP;
          else if (|(d_grant & dWEN)) state_d = WB;
          else                        state_d = INV;
        end else if (|i_grant) begin
          req_d    = i_idx;
          rr_ptr_d = (i_idx == LAST_IDX) ? '0 : i_idx + IDX_W'(1);
          state_d  = IFETCH;
        end
      end
      IFETCH: if (access) state_d = IDLE;
      SNOOP: begin
        // Lowest-numbered Modified holder supplies the block.
        for (int j = int'(CPUS) - 1; j >= 0; j--) begin
          if (src_cand[j]) src_d = IDX_W'(j);
        end
        state_d = (|src_cand) ? C2C : M2C;
      end
      WB, C2C, M2C: begin
        if (last_beat) begin
          beat_d  = '0;
          state_d = IDLE;
        end else if (access) begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      INV:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs decode from the current state; everything is gated to the latched requester.
  always_comb begin
    iwait       = '1;
    iload       = '0;
    dwait       = '1;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    case (state_q)
      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr[req_q*ADDR_W +: ADDR_W];
        if (access) begin
          iwait[req_q]                  = 1'b0;
          iload[req_q*WORD_W +: WORD_W] = ramload;
        end
      end
      WB: begin
        ramWEN   = 1'b1;
        ramaddr  = req_daddr;
        ramstore = req_dstore;
        if (access) dwait[req_q] = 1'b0;
      end
      SNOOP, INV: begin
        ccwait                              = ~req_oh;
        ccsnoopaddr                         = {CPUS{req_daddr}};
        ccsnoopaddr[req_q*ADDR_W +: ADDR_W] = '0;
        if (state_q == INV) begin
          ccinv        = ~req_oh;
          dwait[req_q] = 1'b0;
        end else if (ccwrite[req_q]) begin
          ccinv = ~req_oh;
        end
      end
      C2C: begin
        ccwait[src_q] = 1'b1;
        ramWEN        = 1'b1;
        ramaddr       = req_daddr;
        ramstore      = src_dstore;
        if (access) begin
          dwait[req_q]                  = 1'b0;
          dload[req_q*WORD_W +: WORD_W] = src_dstore;
        end
      end
      M2C: begin
        ramREN  = 1'b1;
        ramaddr = req_daddr;
        if (access) begin
          dwait[req_q]                  = 1'b0;
          dload[req_q*WORD_W +: WORD_W] = ramload;
        end
      end
      default: ;
    endcase
  end

`ifdef COHERENCE_STATS_EN
  logic [15:0] stat_c2c_q, stat_c2c_d, stat_m2c_q, stat_m2c_d, stat_inv_q, stat_inv_d;

  always_comb begin
    stat_c2c_d = stat_c2c_q;
    stat_m2c_d = stat_m2c_q;
    stat_inv_d = stat_inv_q;
    if (state_q == C2C && last_beat && stat_c2c_q != 16'hFFFF) stat_c2c_d = stat_c2c_q + 16'd1;
    if (state_q == M2C && last_beat && stat_m2c_q != 16'hFFFF) stat_m2c_d = stat_m2c_q + 16'd1;
    if (state_q == INV && stat_inv_q != 16'hFFFF)              stat_inv_d = stat_inv_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_c2c_q <= '0;
      stat_m2c_q <= '0;
      stat_inv_q <= '0;
    end else begin
      stat_c2c_q <= stat_c2c_d;
      stat_m2c_q <= stat_m2c_d;
      stat_inv_q <= stat_inv_d;
    end
  end

  assign stat_c2c = stat_c2c_q;
  assign stat_m2c = stat_m2c_q;
  assign stat_inv = stat_inv_q;
`endif

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl (CPUS=4, 2-word blocks) with a 1-cycle RAM model.
// Stat counter checks are compiled in when COHERENCE_STATS_EN is defined.
module tb_coherence_bus_ctrl;
  import coherence_pkg::*;

  localparam int unsigned CPUS = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [CPUS-1:0]  iREN = '0, dREN = '0, dWEN = '0, ccwrite = '0, cctrans = '0;
  logic [CPUS*32-1:0] iaddr = '0, daddr = '0, dstore = '0;
  logic [CPUS-1:0]  iwait, dwait, ccwait, ccinv;
  logic [CPUS*32-1:0] iload, dload, ccsnoopaddr;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  ramstate_t        ramstate;
  logic             ram_stall = 1'b0;
`ifdef COHERENCE_STATS_EN
  logic [15:0]      stat_c2c, stat_m2c, stat_inv;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem    [512];
  bit          wvalid [512];

  always #5 CLK = ~CLK;

  // Unwritten RAM words read back as 0x5A00_0000 | word index.
  assign ramstate = (!ram_stall && (ramREN || ramWEN)) ? ACCESS : FREE;
  assign ramload  = !ramREN ? 32'h0 :
                    wvalid[ramaddr[10:2]] ? mem[ramaddr[10:2]] : (32'h5A00_0000 | 32'(ramaddr[10:2]));

  always @(posedge CLK) begin
    if (ramWEN && !ram_stall) begin
      mem[ramaddr[10:2]]    <= ramstore;
      wvalid[ramaddr[10:2]] <= 1'b1;
    end
  end

  coherence_bus_ctrl #(.CPUS(CPUS), .ADDR_W(32), .WORD_W(32), .BLOCK_WORDS(2)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ccwrite(ccwrite), .cctrans(cctrans), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
`ifdef COHERENCE_STATS_EN
    , .stat_c2c(stat_c2c), .stat_m2c(stat_m2c), .stat_inv(stat_inv)
`endif
  );

  function automatic logic [31:0] w32(input logic [CPUS*32-1:0] v, input int i);
    return v[i*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) tick();
    RST = 1'b0;
    #1;
    vectors++; if ({iwait, dwait} !== 8'hFF) begin miscompares++; $display("FAIL reset_wait: got %h want ff", {iwait, dwait}); end
    vectors++; if ({ccwait, ccinv, ramREN, ramWEN} !== 10'h0) begin miscompares++; $display("FAIL reset_cc_ram: got %h want 0", {ccwait, ccinv, ramREN, ramWEN}); end
    vectors++; if ({iload, dload, ccsnoopaddr} !== '0) begin miscompares++; $display("FAIL reset_data: nonzero data outputs"); end
    vectors++; if (dut.state_q !== IDLE || dut.rr_ptr_q !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d/%0d want IDLE/0", dut.state_q, dut.rr_ptr_q); end
  endtask

  task automatic test_ifetch_rr();
    int exp_g [5] = '{0, 1, 2, 3, 0};
    iaddr = {32'h40C, 32'h408, 32'h404, 32'h400};
    iREN  = 4'hF;
    for (int n = 0; n < 5; n++) begin
      tick();
      #1;
      vectors++;
      if (iwait !== ~(4'b0001 << exp_g[n]) || w32(iload, exp_g[n]) !== (32'h5A00_0100 + 32'(exp_g[n])) || ramREN !== 1'b1) begin
        miscompares++;
        $display("FAIL ifetch_rr%0d: iwait %b iload %h want core %0d data %h", n, iwait, w32(iload, exp_g[n]), exp_g[n], 32'h5A00_0100 + 32'(exp_g[n]));
      end
      if (n == 4) iREN = '0;
      tick();
      #1;
      vectors++; if (iwait !== 4'hF || ramREN !== 1'b0) begin miscompares++; $display("FAIL ifetch_idle%0d: iwait %b ramREN %b want 1111/0", n, iwait, ramREN); end
    end
  endtask

  task automatic test_m2c();
    dREN[0] = 1'b1;
    daddr[31:0] = 32'h100;
    tick(); #1;
    vectors++; if (ccwait !== 4'b1110 || ccinv !== 4'b0000 || w32(ccsnoopaddr, 1) !== 32'h100 || dwait !== 4'hF) begin
      miscompares++; $display("FAIL m2c_snoop: ccwait %b ccinv %b snoop %h dwait %b want 1110/0000/100/1111", ccwait, ccinv, w32(ccsnoopaddr, 1), dwait); end
    tick(); #1;
    vectors++; if ({ramREN, ramWEN} !== 2'b10 || ramaddr !== 32'h100 || dwait !== 4'b1110 || w32(dload, 0) !== 32'h5A00_0040) begin
      miscompares++; $display("FAIL m2c_beat0: ram %b addr %h dwait %b dload %h want 10/100/1110/5a000040", {ramREN, ramWEN}, ramaddr, dwait, w32(dload, 0)); end
    tick();
    daddr[31:0] = 32'h104;
    #1;
    vectors++; if (ramaddr !== 32'h104 || dwait !== 4'b1110 || w32(dload, 0) !== 32'h5A00_0041) begin
      miscompares++; $display("FAIL m2c_beat1: addr %h dwait %b dload %h want 104/1110/5a000041", ramaddr, dwait, w32(dload, 0)); end
    dREN = '0;
    tick(); #1;
    vectors++; if (dwait !== 4'hF || ramREN !== 1'b0 || dut.state_q !== IDLE) begin
      miscompares++; $display("FAIL m2c_done: dwait %b ramREN %b state %0d want 1111/0/IDLE", dwait, ramREN, dut.state_q); end
  endtask

  task automatic test_c2c();
    dREN[1] = 1'b1;
    daddr[63:32] = 32'h200;
    cctrans[0] = 1'b1;
    dstore[31:0] = 32'hC0C0_0000;
    tick(); #1;
    vectors++; if (ccwait !== 4'b1101 || ccinv !== 4'b0000 || w32(ccsnoopaddr, 0) !== 32'h200) begin
      miscompares++; $display("FAIL c2c_snoop: ccwait %b ccinv %b snoop %h want 1101/0000/200", ccwait, ccinv, w32(ccsnoopaddr, 0)); end
    tick(); #1;
    vectors++; if (ccwait !== 4'b0001 || {ramREN, ramWEN} !== 2'b01 || ramaddr !== 32'h200 || ramstore !== 32'hC0C0_0000) begin
      miscompares++; $display("FAIL c2c_beat0_ram: ccwait %b ram %b addr %h store %h want 0001/01/200/c0c00000", ccwait, {ramREN, ramWEN}, ramaddr, ramstore); end
    vectors++; if (dwait !== 4'b1101 || w32(dload, 1) !== 32'hC0C0_0000) begin
      miscompares++; $display("FAIL c2c_beat0_load: dwait %b dload %h want 1101/c0c00000", dwait, w32(dload, 1)); end
    tick();
    dstore[31:0] = 32'hD0D0_0001;
    daddr[63:32] = 32'h204;
    #1;
    vectors++; if (ccwait !== 4'b0001 || ramaddr !== 32'h204 || ramstore !== 32'hD0D0_0001 || w32(dload, 1) !== 32'hD0D0_0001 || dwait !== 4'b1101) begin
      miscompares++; $display("FAIL c2c_beat1: ccwait %b addr %h store %h dload %h dwait %b want 0001/204/d0d00001/d0d00001/1101", ccwait, ramaddr, ramstore, w32(dload, 1), dwait); end
    dREN = '0;
    cctrans = '0;
    tick(); #1;
    vectors++; if (ccwait !== 4'b0000 || ramWEN !== 1'b0 || dwait !== 4'hF) begin
      miscompares++; $display("FAIL c2c_done: ccwait %b ramWEN %b dwait %b want 0000/0/1111", ccwait, ramWEN, dwait); end
    vectors++; if (mem[9'h080] !== 32'hC0C0_0000 || mem[9'h081] !== 32'hD0D0_0001) begin
      miscompares++; $display("FAIL c2c_ram_wb: got %h %h want c0c00000 d0d00001", mem[9'h080], mem[9'h081]); end
  endtask

  task automatic test_inv();
    ccwrite[2] = 1'b1;
    daddr[95:64] = 32'h300;
    tick(); #1;
    vectors++; if (ccinv !== 4'b1011 || ccwait !== 4'b1011 || dwait !== 4'b1011 || {ramREN, ramWEN} !== 2'b00) begin
      miscompares++; $display("FAIL inv_cycle: ccinv %b ccwait %b dwait %b ram %b want 1011/1011/1011/00", ccinv, ccwait, dwait, {ramREN, ramWEN}); end
    vectors++; if (w32(ccsnoopaddr, 0) !== 32'h300 || w32(ccsnoopaddr, 1) !== 32'h300 || w32(ccsnoopaddr, 3) !== 32'h300 || w32(ccsnoopaddr, 2) !== 32'h0) begin
      miscompares++; $display("FAIL inv_snoopaddr: got %h want 300/300/0/300 in cores 0..3", ccsnoopaddr); end
    ccwrite = '0;
    tick(); #1;
    vectors++; if (ccinv !== 4'b0000 || dwait !== 4'hF || dut.state_q !== IDLE) begin
      miscompares++; $display("FAIL inv_done: ccinv %b dwait %b state %0d want 0000/1111/IDLE", ccinv, dwait, dut.state_q); end
  endtask

  task automatic test_priority();
`ifdef COHERENCE_STATS_EN
    logic [15:0] m2c_before = stat_m2c;
`endif
    dREN[0] = 1'b1;
    daddr[31:0] = 32'h100;
    iREN[1] = 1'b1;
    tick(); #1;
    vectors++; if (dut.state_q !== SNOOP || ccwait !== 4'b1110 || iwait !== 4'hF) begin
      miscompares++; $display("FAIL prio_grant: state %0d ccwait %b iwait %b want SNOOP/1110/1111", dut.state_q, ccwait, iwait); end
    tick(); #1;
    vectors++; if (w32(dload, 0) !== 32'h5A00_0040 || dwait !== 4'b1110 || iwait !== 4'hF) begin
      miscompares++; $display("FAIL prio_beat0: dload %h dwait %b iwait %b want 5a000040/1110/1111", w32(dload, 0), dwait, iwait); end
    tick();
    daddr[31:0] = 32'h104;
    #1;
    vectors++; if (w32(dload, 0) !== 32'h5A00_0041 || dwait !== 4'b1110) begin
      miscompares++; $display("FAIL prio_beat1: dload %h dwait %b want 5a000041/1110", w32(dload, 0), dwait); end
    dREN = '0;
    tick(); #1;
`ifdef COHERENCE_STATS_EN
    vectors++; if (stat_m2c !== m2c_before + 16'd1) begin miscompares++; $display("FAIL stat_m2c_incr: got %0d want %0d", stat_m2c, m2c_before + 16'd1); end
    vectors++; if (stat_c2c !== 16'd1 || stat_inv !== 16'd1 || stat_m2c !== 16'd2) begin
      miscompares++; $display("FAIL stat_totals: c2c %0d m2c %0d inv %0d want 1/2/1", stat_c2c, stat_m2c, stat_inv); end
`endif
    vectors++; if (dut.state_q !== IDLE || iwait !== 4'hF) begin
      miscompares++; $display("FAIL prio_gap: state %0d iwait %b want IDLE/1111", dut.state_q, iwait); end
    tick(); #1;
    vectors++; if (iwait !== 4'b1101 || w32(iload, 1) !== 32'h5A00_0101) begin
      miscompares++; $display("FAIL prio_ifetch: iwait %b iload %h want 1101/5a000101", iwait, w32(iload, 1)); end
    iREN = '0;
    tick(); #1;
  endtask

  task automatic test_reset_mid_burst();
    ram_stall = 1'b1;
    dREN[3] = 1'b1;
    daddr[127:96] = 32'h100;
    repeat (2) tick();
    #1;
    vectors++; if (dut.state_q !== M2C || ramREN !== 1'b1 || dwait !== 4'hF) begin
      miscompares++; $display("FAIL rstmid_stalled: state %0d ramREN %b dwait %b want M2C/1/1111", dut.state_q, ramREN, dwait); end
    dREN = '0;
    RST = 1'b1;
    repeat (2) tick();
    RST = 1'b0;
    ram_stall = 1'b0;
    #1;
    vectors++; if ({ramREN, ramWEN} !== 2'b00 || dwait !== 4'hF || iwait !== 4'hF || dut.state_q !== IDLE || dut.beat_q !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_after: ram %b dwait %b iwait %b state %0d want 00/1111/1111/IDLE", {ramREN, ramWEN}, dwait, iwait, dut.state_q); end
`ifdef COHERENCE_STATS_EN
    vectors++; if ({stat_c2c, stat_m2c, stat_inv} !== 48'h0) begin miscompares++; $display("FAIL stat_clear: got %h want 0", {stat_c2c, stat_m2c, stat_inv}); end
`endif
    tick(); #1;
    vectors++; if ({ramREN, ramWEN} !== 2'b00 || dut.state_q !== IDLE) begin
      miscompares++; $display("FAIL rstmid_quiet: ram %b state %0d want 00/IDLE", {ramREN, ramWEN}, dut.state_q); end
  endtask

  initial begin
    test_reset();
    test_ifetch_rr();
    test_m2c();
    test_c2c();
    test_inv();
    test_priority();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
